// File: rtl/rf_gather_mac_if.sv
// Job and activation-buffer bus for the gather/MAC stage.
// The job issuer / activation buffer side uses the master modport;
// rf_gather_mac uses the slave modport.
interface rf_gather_mac_if #(
  parameter int N_ENT = 16,
  parameter int AW    = 7,
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 24
);
  localparam int LW = $clog2(N_ENT) + 1;

  // job request
  logic                              i_start;
  logic [LW-1:0]                     i_length;
  logic [N_ENT-1:0][2:0][AW-1:0]     i_rf;     // [e][0]=h, [e][1]=w, [e][2]=k
  logic [N_ENT-1:0][WGT_W-1:0]       i_wgt;

  // activation buffer read port
  logic                              o_act_req;
  logic [AW-1:0]                     o_act_h;
  logic [AW-1:0]                     o_act_w;
  logic [AW-1:0]                     o_act_k;
  logic [ACT_W-1:0]                  i_act_data;

  // job status / result
  logic                              o_busy;
  logic                              o_valid;
  logic [ACC_W-1:0]                  o_sum;

  modport master (
    output i_start, i_length, i_rf, i_wgt, i_act_data,
    input  o_act_req, o_act_h, o_act_w, o_act_k, o_busy, o_valid, o_sum
  );

  modport slave (
    input  i_start, i_length, i_rf, i_wgt, i_act_data,
    output o_act_req, o_act_h, o_act_w, o_act_k, o_busy, o_valid, o_sum
  );
endinterface

// File: rtl/rf_gather_mac.sv
// Gather/MAC stage: walks a snapshot of (h, w, k) addresses one entry per
// cycle, reads each in-bounds activation from the buffer, and accumulates
// sum(act * wgt) into one signed partial sum per job.
module rf_gather_mac #(
  parameter int N_ENT  = 16,
  parameter int AW     = 7,
  parameter int IA_ROW = 32,
  parameter int ACT_W  = 8,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 24
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rf_gather_mac_if.slave bus
);
  localparam int LW = $clog2(N_ENT) + 1;   // length field, 0..N_ENT
  localparam int IW = $clog2(N_ENT);       // entry index
  localparam int PW = ACT_W + WGT_W + 1;   // exact product width

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [LW-1:0]                   len_q, len_d;
  logic [IW-1:0]                   cnt_q, cnt_d;
  logic [N_ENT-1:0][2:0][AW-1:0]   rf_q, rf_d;
  logic [N_ENT-1:0][WGT_W-1:0]     wgt_q, wgt_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic signed [ACC_W-1:0]         sum_q, sum_d;
  logic                            act_req_q, act_req_d;
  logic [AW-1:0]                   act_h_q, act_h_d;
  logic [AW-1:0]                   act_w_q, act_w_d;
  logic [AW-1:0]                   act_k_q, act_k_d;
  logic [WGT_W-1:0]                iss_wgt_q, iss_wgt_d;  // weight of entry on the bus now
  logic                            rsp_q, rsp_d;          // read data arrives this cycle
  logic [WGT_W-1:0]                rsp_wgt_q, rsp_wgt_d;  // weight paired with that data
  logic                            busy_q, busy_d;
  logic                            valid_q, valid_d;

  logic [LW-1:0]                   len_in;
  logic [IW-1:0]                   nxt_idx;
  logic                            load_ent;
  logic [AW-1:0]                   ent_h, ent_w, ent_k;
  logic [WGT_W-1:0]                ent_wgt;
  logic [PW-1:0]                   act_ext, wgt_ext;
  logic signed [PW-1:0]            prod;
  logic signed [ACC_W-1:0]         prod_ext, acc_upd;

  // h and w are signed; anything outside 0..IA_ROW-1 is padding.
  function automatic logic in_bounds(input logic [AW-1:0] h, input logic [AW-1:0] w);
    in_bounds = !h[AW-1] && !w[AW-1] &&
                (32'(h) < 32'(IA_ROW)) && (32'(w) < 32'(IA_ROW));
  endfunction

  // Multiply the returning activation (unsigned) by its weight (signed), then widen.
  always_comb begin
    act_ext  = {{(WGT_W + 1){1'b0}}, bus.i_act_data};
    wgt_ext  = {{(ACT_W + 1){rsp_wgt_q[WGT_W-1]}}, rsp_wgt_q};
    prod     = $signed(act_ext) * $signed(wgt_ext);
    prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    acc_upd  = rsp_q ? (acc_q + prod_ext) : acc_q;
  end

  // Next-state logic for the job FSM and all registered outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rf_d      = rf_q;
    wgt_d     = wgt_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    act_req_d = 1'b0;
    act_h_d   = act_h_q;
    act_w_d   = act_w_q;
    act_k_d   = act_k_q;
    iss_wgt_d = iss_wgt_q;
    rsp_d     = act_req_q;
    rsp_wgt_d = iss_wgt_q;
    busy_d    = 1'b0;
    valid_d   = 1'b0;
    load_ent  = 1'b0;
    ent_h     = '0;
    ent_w     = '0;
    ent_k     = '0;
    ent_wgt   = '0;
    len_in    = (bus.i_length > LW'(N_ENT)) ? LW'(N_ENT) : bus.i_length;
    nxt_idx   = cnt_q + IW'(1);

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          len_d  = len_in;
          rf_d   = bus.i_rf;
          wgt_d  = bus.i_wgt;
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (len_in == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
            sum_d   = '0;
          end else begin
            // entry 0 goes out straight from the inputs so it issues next cycle
            state_d  = ISSUE;
            load_ent = 1'b1;
            ent_h    = bus.i_rf[0][0];
            ent_w    = bus.i_rf[0][1];
            ent_k    = bus.i_rf[0][2];
            ent_wgt  = bus.i_wgt[0];
          end
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        acc_d  = acc_upd;
        if (LW'(cnt_q) == len_q - LW'(1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d    = nxt_idx;
          load_ent = 1'b1;
          ent_h    = rf_q[nxt_idx][0];
          ent_w    = rf_q[nxt_idx][1];
          ent_k    = rf_q[nxt_idx][2];
          ent_wgt  = wgt_q[nxt_idx];
        end
      end
      DRAIN: begin
        // last response lands now; publish the final sum with the valid pulse
        busy_d  = 1'b1;
        acc_d   = acc_upd;
        sum_d   = acc_upd;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_ent) begin
      act_req_d = in_bounds(ent_h, ent_w);
      act_h_d   = ent_h;
      act_w_d   = ent_w;
      act_k_d   = ent_k;
      iss_wgt_d = ent_wgt;
    end
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      rf_q      <= '0;
      wgt_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      act_req_q <= 1'b0;
      act_h_q   <= '0;
      act_w_q   <= '0;
      act_k_q   <= '0;
      iss_wgt_q <= '0;
      rsp_q     <= 1'b0;
      rsp_wgt_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rf_q      <= rf_d;
      wgt_q     <= wgt_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      act_req_q <= act_req_d;
      act_h_q   <= act_h_d;
      act_w_q   <= act_w_d;
      act_k_q   <= act_k_d;
      iss_wgt_q <= iss_wgt_d;
      rsp_q     <= rsp_d;
      rsp_wgt_q <= rsp_wgt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.o_act_req = act_req_q;
  assign bus.o_act_h   = act_h_q;
  assign bus.o_act_w   = act_w_q;
  assign bus.o_act_k   = act_k_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_sum     = sum_q;
endmodule

// File: tb/tb_rf_gather_mac.sv
// Directed bench for rf_gather_mac. Cycle 0 is the cycle in which i_start is
// high; the activation buffer is modelled as a table indexed by the k field,
// answering one cycle after each request.
module tb_rf_gather_mac;
  localparam int N_ENT  = 16;
  localparam int AW     = 7;
  localparam int IA_ROW = 32;
  localparam int ACT_W  = 8;
  localparam int WGT_W  = 8;
  localparam int ACC_W  = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_gather_mac_if #(.N_ENT(N_ENT), .AW(AW), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) bus ();

  rf_gather_mac #(
    .N_ENT(N_ENT), .AW(AW), .IA_ROW(IA_ROW), .ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc, req_cnt, busy_cnt, valid_cnt, valid_cyc, first_req, last_req;
  logic [AW-1:0]           last_k;
  logic signed [ACC_W-1:0] valid_sum;
  logic [ACT_W-1:0]        act_tab [16];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; req_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    valid_cyc = -1; first_req = -1; last_req = -1; last_k = '0; valid_sum = '0;
  endtask

  // one clock: answer last cycle's request, then sample outputs 1 unit after the edge
  task automatic step();
    logic          req_prev;
    logic [AW-1:0] k_prev;
    req_prev = bus.o_act_req;
    k_prev   = bus.o_act_k;
    @(posedge clk);
    #1;
    bus.i_act_data = req_prev ? act_tab[k_prev[3:0]] : '0;
    cyc++;
    if (bus.o_act_req) begin
      req_cnt++;
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      last_k   = bus.o_act_k;
    end
    if (bus.o_busy) busy_cnt++;
    if (bus.o_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      valid_sum = $signed(bus.o_sum);
    end
  endtask

  task automatic set_ent(input int e, input logic [AW-1:0] h, input logic [AW-1:0] w,
                         input logic [AW-1:0] k, input int wgt);
    bus.i_rf[e][0] = h;
    bus.i_rf[e][1] = w;
    bus.i_rf[e][2] = k;
    bus.i_wgt[e]   = WGT_W'(wgt);
  endtask

  task automatic start_job(input int len);
    clear_mon();
    bus.i_length = 5'(len);
    bus.i_start  = 1'b1;
    step();
    bus.i_start  = 1'b0;
  endtask

  task automatic run_to_valid(input int budget);
    int n;
    n = 0;
    while (valid_cnt == 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_length   = '0;
    bus.i_rf       = '0;
    bus.i_wgt      = '0;
    bus.i_act_data = '0;
    for (int i = 0; i < 16; i++) act_tab[i] = '0;

    // reset state
    #1;
    check("rst_req",   bus.o_act_req, 0);
    check("rst_busy",  bus.o_busy, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_sum",   $signed(bus.o_sum), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // 1: L=3, in-bounds, act 10/20/30, wgt 1/-2/3 -> 60
    act_tab[0] = 8'd10; act_tab[1] = 8'd20; act_tab[2] = 8'd30;
    set_ent(0, 7'd0, 7'd0, 7'd0, 1);
    set_ent(1, 7'd1, 7'd1, 7'd1, -2);
    set_ent(2, 7'd31, 7'd31, 7'd2, 3);
    start_job(3);
    run_to_valid(20);
    check("t1_req_cnt",   req_cnt, 3);
    check("t1_first_req", first_req, 1);
    check("t1_last_req",  last_req, 3);
    check("t1_last_k",    last_k, 2);
    check("t1_valid_cyc", valid_cyc, 5);
    check("t1_sum",       valid_sum, 60);
    step();
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_busy_cnt",  busy_cnt, 5);
    check("t1_sum_hold",  $signed(bus.o_sum), 60);
    $display("job1 L=3 valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);

    // 3: L=0 -> valid at cycle 1, sum 0, one busy cycle, no request
    start_job(0);
    run_to_valid(10);
    step();
    check("t3_valid_cyc", valid_cyc, 1);
    check("t3_sum",       valid_sum, 0);
    check("t3_busy_cnt",  busy_cnt, 1);
    check("t3_req_cnt",   req_cnt, 0);
    $display("job3 L=0 valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);

    // 4: L=16, act 255, wgt -128 -> -522240
    for (int e = 0; e < 16; e++) begin
      act_tab[e] = 8'd255;
      set_ent(e, 7'd1, 7'd1, 7'(e), -128);
    end
    start_job(16);
    run_to_valid(40);
    check("t4_valid_cyc", valid_cyc, 18);
    check("t4_sum",       valid_sum, -522240);
    check("t4_req_cnt",   req_cnt, 16);
    $display("job4 L=16 valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    step();

    // length above N_ENT clamps to N_ENT: 16 entries of 1*1
    for (int e = 0; e < 16; e++) begin
      act_tab[e] = 8'd1;
      set_ent(e, 7'd2, 7'd5, 7'(e), 1);
    end
    start_job(31);
    run_to_valid(40);
    check("clamp_valid_cyc", valid_cyc, 18);
    check("clamp_sum",       valid_sum, 16);
    $display("clamp L=31 valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    step();

    // 2: L=2, entry0 h=-1, entry1 w=IA_ROW -> all padding, sum 0
    act_tab[0] = 8'd9; act_tab[1] = 8'd9;
    set_ent(0, 7'h7F, 7'd0, 7'd0, 5);
    set_ent(1, 7'd0, 7'd32, 7'd1, 5);
    start_job(2);
    run_to_valid(20);
    check("t2_req_cnt",   req_cnt, 0);
    check("t2_valid_cyc", valid_cyc, 4);
    check("t2_sum",       valid_sum, 0);
    $display("job2 L=2 padding valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    step();

    // 5: restart and array changes during ISSUE are ignored; 2*(3+4+5+6)=36
    act_tab[0] = 8'd3; act_tab[1] = 8'd4; act_tab[2] = 8'd5; act_tab[3] = 8'd6;
    for (int e = 0; e < 4; e++) set_ent(e, 7'd4, 7'd4, 7'(e), 2);
    start_job(4);
    step();
    bus.i_start  = 1'b1;
    bus.i_length = 5'd1;
    for (int e = 0; e < 4; e++) set_ent(e, 7'd4, 7'd4, 7'd0, 100);
    step();
    bus.i_start = 1'b0;
    run_to_valid(20);
    check("t5_valid_cyc", valid_cyc, 6);
    check("t5_sum",       valid_sum, 36);
    check("t5_req_cnt",   req_cnt, 4);
    check("t5_valid_cnt", valid_cnt, 1);
    $display("job5 L=4 restart-ignored valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    // start held from the valid cycle: ignored in DONE, accepted the next cycle
    set_ent(0, 7'd2, 7'd2, 7'd1, 5);
    bus.i_length = 5'd1;
    bus.i_start  = 1'b1;
    step();
    check("t5_idle_gap_busy", bus.o_busy, 0);
    clear_mon();
    step();
    bus.i_start = 1'b0;
    run_to_valid(10);
    check("t5b_valid_cyc", valid_cyc, 3);
    check("t5b_sum",       valid_sum, 20);
    $display("job5b L=1 back-to-back valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    step();

    // 6: reset at cycle 2 of an L=8 job, then a fresh L=1 job -> 35
    for (int e = 0; e < 8; e++) begin
      act_tab[e] = 8'(e + 1);
      set_ent(e, 7'd3, 7'd3, 7'(e), 1);
    end
    start_job(8);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",   bus.o_act_req, 0);
    check("t6_rst_busy",  bus.o_busy, 0);
    check("t6_rst_valid", bus.o_valid, 0);
    check("t6_rst_sum",   $signed(bus.o_sum), 0);
    check("t6_rst_h",     bus.o_act_h, 0);
    clear_mon();
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("t6_no_valid", valid_cnt, 0);
    check("t6_no_req",   req_cnt, 0);
    check("t6_no_busy",  busy_cnt, 0);
    act_tab[0] = 8'd7;
    set_ent(0, 7'd1, 7'd1, 7'd0, 5);
    start_job(1);
    run_to_valid(10);
    check("t6_valid_cyc", valid_cyc, 3);
    check("t6_sum",       valid_sum, 35);
    $display("job6 post-reset L=1 valid_cyc=%0d sum=%0d", valid_cyc, valid_sum);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
